// File: rtl/serial_byte_tx_if.sv
// Byte handshake between a producer and the serial transmit stage.
// The producer drives in_data and in_valid, and the transmitter answers with in_ready.
interface serial_byte_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_byte_tx.sv
// Serialising transmit stage: a small byte FIFO feeding a start/data/parity/stop framer.
// The line moves one bit per clk. Consecutive frames are sent back to back, with no idle gap.
module serial_byte_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_byte_tx_if.slave               s_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Framer state
  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_tx;
  logic              r_busy;
  logic              r_frame_done;

  // Next-state signals from the framer
  state_t            w_state_next;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_par_next;
  logic [BIT_W-1:0]  w_bit_cnt_next;
  logic              w_tx_next;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_head;
  logic              w_have_byte;

  // in_ready depends only on the registered count, so it never waits on in_valid.
  assign s_in.in_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push        = s_in.in_valid && s_in.in_ready;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_have_byte   = (r_count != '0);

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign fifo_count = r_count;

  // FIFO data array: written on push only
  // NOTE: the storage array has no reset. The pointers and the count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
  end

  // FIFO pointers and occupancy. A push and a pop at the same edge leave the count unchanged.
  // NOTE: sequential state uses non-blocking assignments only, so every block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Framer state register. The line outputs are registered so that they show the state just entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_bit_cnt    <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_par        <= w_par_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_tx         <= w_tx_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (w_state_next == S_STOP) && (w_bit_cnt_next == BIT_W'(STOP_BITS - 1));
    end
  end

  // Next-state logic, FIFO pop decision, and the line value for the state being entered
  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_bit_cnt_next = r_bit_cnt;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_have_byte) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_par_next   = (^w_head) ^ PARITY_ODD;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_bit_cnt_next = '0;
        w_state_next   = S_DATA;
      end
      S_DATA: begin
        w_shift_next   = r_shift >> 1;
        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
        if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
          w_bit_cnt_next = '0;
          w_state_next   = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_bit_cnt_next = '0;
        w_state_next   = S_STOP;
      end
      S_STOP: begin
        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
        if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
          w_bit_cnt_next = '0;
          if (w_have_byte) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_par_next   = (^w_head) ^ PARITY_ODD;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_par_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

endmodule
